// File: rtl/cae_aeg_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : cae_aeg_dispatch
// Brief    : AEG register file plus CAEP dispatch FSM with kernel start/done
//            handshake and watchdog. Optional busy-cycle counter at AEG index
//            NA when CAE_PERF_CNT_EN is defined.
// Revision : 1.0
// ============================================================================
module cae_aeg_dispatch #(
    parameter int          NA         = 51,
    parameter int          NB         = 6,
    parameter logic [31:0] CAEP_MASK  = 32'h0000_0001,
    parameter int          TMO_CYCLES = 0
) (
    input  logic          clk,
    input  logic          i_reset,
    input  logic          inst_val,
    input  logic [4:0]    inst_caep,
    input  logic          inst_aeg_wr,
    input  logic          inst_aeg_rd,
    input  logic [17:0]   inst_aeg_idx,
    input  logic          err_unimpl,
    input  logic [63:0]   cae_data,
    output logic [17:0]   cae_aeg_cnt,
    output logic [63:0]   cae_ret_data,
    output logic          cae_ret_data_vld,
    output logic [15:0]   cae_exception,
    output logic          cae_idle,
    output logic          cae_stall,
    output logic          k_start,
    output logic [4:0]    k_caep,
    input  logic          k_done,
    input  logic          k_wr_vld,
    input  logic [NB-1:0] k_wr_idx,
    input  logic [63:0]   k_wr_data,
    input  logic [NB-1:0] k_rd_idx,
    output logic [63:0]   k_rd_data
);

`ifdef CAE_PERF_CNT_EN
    localparam int NREG = NA + 1;
`else
    localparam int NREG = NA;
`endif
    localparam logic [31:0] NA_U   = 32'(NA);
    localparam logic [31:0] LIM_U  = 32'(NREG);
    localparam logic [31:0] TMO_U  = 32'(TMO_CYCLES);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_BUSY = 2'd2} state_t;

    state_t        state_q, state_d;
    logic [63:0]   aeg_q [NA];
    logic [63:0]   aeg_d [NA];
    logic [4:0]    k_caep_q, k_caep_d;
    logic [15:0]   exc_q, exc_d;
    logic          ret_vld_q, ret_vld_d;
    logic [63:0]   ret_data_q, ret_data_d;
    logic [31:0]   tmo_q, tmo_d;
    logic [63:0]   cnt_val;

    logic [31:0]   host_idx;
    logic [NB-1:0] hidx;
    logic          host_in;
    logic          host_reg;

`ifdef CAE_PERF_CNT_EN
    logic [63:0] perf_q, perf_d;
    assign cnt_val = perf_q;
    assign perf_d  = (state_q != S_IDLE) ? perf_q + 64'd1 : perf_q;

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) perf_q <= '0;
        else         perf_q <= perf_d;
    end
`else
    assign cnt_val = '0;
`endif

    assign host_idx = 32'(inst_aeg_idx);
    assign hidx     = inst_aeg_idx[NB-1:0];
    assign host_in  = host_idx < LIM_U;
    assign host_reg = host_idx < NA_U;

    always_comb begin
        state_d    = state_q;
        k_caep_d   = k_caep_q;
        exc_d      = '0;
        ret_vld_d  = 1'b0;
        ret_data_d = ret_data_q;
        tmo_d      = tmo_q;
        aeg_d      = aeg_q;

        exc_d[0] = err_unimpl | (inst_val & ~CAEP_MASK[inst_caep]);
        exc_d[1] = (inst_aeg_rd | inst_aeg_wr) & ~host_in;
        exc_d[3] = inst_val & (state_q != S_IDLE);

        if (inst_aeg_rd && host_in) begin
            ret_vld_d  = 1'b1;
            ret_data_d = host_reg ? aeg_q[hidx] : cnt_val;
        end

        // Host write is applied last so it wins a same-index collision.
        if (k_wr_vld && (32'(k_wr_idx) < NA_U)) aeg_d[k_wr_idx] = k_wr_data;
        if (inst_aeg_wr && host_reg)            aeg_d[hidx]     = cae_data;

        case (state_q)
            S_IDLE: begin
                if (inst_val && CAEP_MASK[inst_caep]) begin
                    k_caep_d = inst_caep;
                    state_d  = S_START;
                end
            end
            S_START: begin
                tmo_d   = 32'd1;
                state_d = S_BUSY;
            end
            S_BUSY: begin
                if (k_done) begin
                    state_d = S_IDLE;
                end else if ((TMO_U != 32'd0) && (tmo_q == TMO_U)) begin
                    exc_d[2] = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            k_caep_q   <= '0;
            exc_q      <= '0;
            ret_vld_q  <= 1'b0;
            ret_data_q <= '0;
            tmo_q      <= '0;
            for (int i = 0; i < NA; i++) aeg_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            k_caep_q   <= k_caep_d;
            exc_q      <= exc_d;
            ret_vld_q  <= ret_vld_d;
            ret_data_q <= ret_data_d;
            tmo_q      <= tmo_d;
            for (int i = 0; i < NA; i++) aeg_q[i] <= aeg_d[i];
        end
    end

    assign cae_aeg_cnt      = 18'(NREG);
    assign cae_ret_data     = ret_data_q;
    assign cae_ret_data_vld = ret_vld_q;
    assign cae_exception    = exc_q;
    assign cae_idle         = (state_q == S_IDLE);
    assign cae_stall        = (state_q != S_IDLE);
    assign k_start          = (state_q == S_START);
    assign k_caep           = k_caep_q;
    assign k_rd_data        = (32'(k_rd_idx) < NA_U) ? aeg_q[k_rd_idx] : '0;

endmodule
`default_nettype wire

// File: tb/tb_cae_aeg_dispatch.sv
`default_nettype none
// ============================================================================
// Module   : tb_cae_aeg_dispatch
// Brief    : Directed bench for cae_aeg_dispatch with a cycle-level reference
//            model and literal spot checks.
// Revision : 1.0
// ============================================================================
module tb_cae_aeg_dispatch;
    localparam int          NA   = 51;
    localparam int          NB   = 6;
    localparam int          TMO  = 16;
    localparam logic [31:0] MASK = 32'h0000_0001;
`ifdef CAE_PERF_CNT_EN
    localparam int LIM = NA + 1;
`else
    localparam int LIM = NA;
`endif

    logic          clk;
    logic          i_reset;
    logic          inst_val;
    logic [4:0]    inst_caep;
    logic          inst_aeg_wr;
    logic          inst_aeg_rd;
    logic [17:0]   inst_aeg_idx;
    logic          err_unimpl;
    logic [63:0]   cae_data;
    logic [17:0]   cae_aeg_cnt;
    logic [63:0]   cae_ret_data;
    logic          cae_ret_data_vld;
    logic [15:0]   cae_exception;
    logic          cae_idle;
    logic          cae_stall;
    logic          k_start;
    logic [4:0]    k_caep;
    logic          k_done;
    logic          k_wr_vld;
    logic [NB-1:0] k_wr_idx;
    logic [63:0]   k_wr_data;
    logic [NB-1:0] k_rd_idx;
    logic [63:0]   k_rd_data;

    cae_aeg_dispatch #(
        .NA(NA), .NB(NB), .CAEP_MASK(MASK), .TMO_CYCLES(TMO)
    ) dut (
        .clk(clk), .i_reset(i_reset), .inst_val(inst_val), .inst_caep(inst_caep),
        .inst_aeg_wr(inst_aeg_wr), .inst_aeg_rd(inst_aeg_rd), .inst_aeg_idx(inst_aeg_idx),
        .err_unimpl(err_unimpl), .cae_data(cae_data), .cae_aeg_cnt(cae_aeg_cnt),
        .cae_ret_data(cae_ret_data), .cae_ret_data_vld(cae_ret_data_vld),
        .cae_exception(cae_exception), .cae_idle(cae_idle), .cae_stall(cae_stall),
        .k_start(k_start), .k_caep(k_caep), .k_done(k_done), .k_wr_vld(k_wr_vld),
        .k_wr_idx(k_wr_idx), .k_wr_data(k_wr_data), .k_rd_idx(k_rd_idx),
        .k_rd_data(k_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: phase 0 = idle, 1 = start cycle, 2 = busy.
    logic [63:0] m_aeg [64];
    int          m_phase;
    int          m_bcnt;
    int          m_idx;
    logic [4:0]  m_caep;
    logic [15:0] m_exc;
    logic        m_vld;
    logic [63:0] m_data;
    logic [63:0] m_perf;
    logic [31:0] m_mask;

    always @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < 64; i++) m_aeg[i] = 64'd0;
            m_phase = 0; m_bcnt = 0; m_caep = 5'd0; m_exc = 16'd0;
            m_vld = 1'b0; m_data = 64'd0; m_perf = 64'd0;
        end else begin
            m_idx    = int'(inst_aeg_idx);
            m_exc    = 16'd0;
            m_exc[0] = err_unimpl || (inst_val && !m_mask[inst_caep]);
            m_exc[1] = (inst_aeg_rd || inst_aeg_wr) && (m_idx >= LIM);
            m_exc[3] = inst_val && (m_phase != 0);
            m_vld    = inst_aeg_rd && (m_idx < LIM);
            if (m_vld) m_data = (m_idx == NA) ? m_perf : m_aeg[m_idx];
            if (k_wr_vld && (int'(k_wr_idx) < NA)) m_aeg[k_wr_idx] = k_wr_data;
            if (inst_aeg_wr && (m_idx < NA)) m_aeg[m_idx] = cae_data;
            if (m_phase != 0) m_perf = m_perf + 64'd1;
            if (m_phase == 0) begin
                if (inst_val && m_mask[inst_caep]) begin m_phase = 1; m_caep = inst_caep; end
            end else if (m_phase == 1) begin
                m_phase = 2; m_bcnt = 1;
            end else begin
                if (k_done) m_phase = 0;
                else if (m_bcnt == TMO) begin m_phase = 0; m_exc[2] = 1'b1; end
                else m_bcnt = m_bcnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en && !i_reset) begin
            chk("idle", cae_idle, m_phase == 0);
            chk("stall", cae_stall, m_phase != 0);
            chk("k_start", k_start, m_phase == 1);
            chk("k_caep", k_caep, m_caep);
            chk("exception", cae_exception, m_exc);
            chk("ret_vld", cae_ret_data_vld, m_vld);
            if (m_vld) chk("ret_data", cae_ret_data, m_data);
            chk("aeg_cnt", cae_aeg_cnt, LIM);
            chk("k_rd_data", k_rd_data, (int'(k_rd_idx) < NA) ? m_aeg[k_rd_idx] : 64'd0);
        end
    end

    task automatic clr();
        inst_val = 0; inst_caep = 0; inst_aeg_wr = 0; inst_aeg_rd = 0; inst_aeg_idx = 0;
        err_unimpl = 0; cae_data = 0; k_done = 0; k_wr_vld = 0; k_wr_idx = 0;
        k_wr_data = 0; k_rd_idx = 0;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic host_rd(input int idx);
        clr(); inst_aeg_rd = 1; inst_aeg_idx = 18'(idx);
        step(); clr();
    endtask

    initial begin
        m_mask = MASK;
        clr();
        i_reset = 1'b1;
        #12;
        chk("rst_idle", cae_idle, 1'b1);
        chk("rst_stall", cae_stall, 1'b0);
        chk("rst_kstart", k_start, 1'b0);
        chk("rst_exc", cae_exception, 16'd0);
        chk("rst_vld", cae_ret_data_vld, 1'b0);
        chk("rst_data", cae_ret_data, 64'd0);
        i_reset = 1'b0;
        @(negedge clk); #1;
        chk_en = 1'b1;

        // Host write then read-during-write
        inst_aeg_wr = 1; inst_aeg_idx = 18'd5; cae_data = 64'h1234_5678_9ABC_DEF0;
        step(); clr();
        inst_aeg_rd = 1; inst_aeg_wr = 1; inst_aeg_idx = 18'd5; cae_data = 64'h55;
        step(); clr();
        chk("rd5_vld", cae_ret_data_vld, 1'b1);
        chk("rd5_data", cae_ret_data, 64'h1234_5678_9ABC_DEF0);
        host_rd(5);
        chk("rd5_new", cae_ret_data, 64'h55);

        // Index NA: out of range, or the perf counter
        host_rd(NA);
`ifdef CAE_PERF_CNT_EN
        chk("rdNA_vld", cae_ret_data_vld, 1'b1);
        chk("rdNA_cnt", cae_ret_data, 64'd0);
        chk("rdNA_exc", cae_exception, 16'd0);
`else
        chk("rdNA_vld", cae_ret_data_vld, 1'b0);
        chk("rdNA_exc", cae_exception, 16'h0002);
`endif
        step();
        chk("exc_pulse_end", cae_exception, 16'd0);
        inst_aeg_wr = 1; inst_aeg_idx = 18'(NA); cae_data = 64'hDEAD;
        step(); clr();
        inst_aeg_wr = 1; inst_aeg_idx = 18'd200; cae_data = 64'hBEEF;
        step(); clr();

        // Kernel dispatch, done at N+11
        inst_val = 1; inst_caep = 5'd0;
        step(); clr();
        chk("N1_kstart", k_start, 1'b1);
        chk("N1_stall", cae_stall, 1'b1);
        chk("N1_idle", cae_idle, 1'b0);
        k_done = 1;
        step(); clr();
        chk("N2_kstart", k_start, 1'b0);
        chk("N2_done_ignored", cae_stall, 1'b1);
        for (int i = 2; i <= 10; i++) begin
            clr();
            if (i == 5) begin inst_val = 1; inst_caep = 5'd0; end
            if (i == 7) begin
                inst_aeg_wr = 1; inst_aeg_idx = 18'd3; cae_data = 64'h1111;
                k_wr_vld = 1; k_wr_idx = 6'd3; k_wr_data = 64'h2222;
            end
            if (i == 8) begin
                inst_aeg_wr = 1; inst_aeg_idx = 18'd4; cae_data = 64'h44;
                k_wr_vld = 1; k_wr_idx = 6'd6; k_wr_data = 64'h66;
            end
            if (i == 9) begin k_wr_vld = 1; k_wr_idx = 6'd60; k_wr_data = 64'hFF; end
            step();
            if (i == 5) chk("busy_inst_exc", cae_exception, 16'h0008);
        end
        clr();
        chk("N11_stall", cae_stall, 1'b1);
        k_done = 1; k_wr_vld = 1; k_wr_idx = 6'd1; k_wr_data = 64'hAA;
        step(); clr();
        chk("N12_idle", cae_idle, 1'b1);
        host_rd(1);
        chk("aeg1", cae_ret_data, 64'hAA);
        host_rd(3);
        chk("collide_host_wins", cae_ret_data, 64'h1111);
        host_rd(4);
        chk("host_wr4", cae_ret_data, 64'h44);
        k_rd_idx = 6'd6; #1;
        chk("k_rd6", k_rd_data, 64'h66);
        k_rd_idx = 6'd60; #1;
        chk("k_rd60", k_rd_data, 64'd0);
        clr();

        // Unimplemented opcode and decoder flag
        inst_val = 1; inst_caep = 5'd3;
        step(); clr();
        chk("unimpl_exc", cae_exception, 16'h0001);
        chk("unimpl_idle", cae_idle, 1'b1);
        chk("unimpl_kstart", k_start, 1'b0);
        err_unimpl = 1;
        step(); clr();
        chk("err_unimpl_exc", cae_exception, 16'h0001);

        // Watchdog
        inst_val = 1; inst_caep = 5'd0;
        step(); clr();
        for (int i = 0; i < TMO; i++) step();
        chk("wd_last_busy_idle", cae_idle, 1'b0);
        chk("wd_last_busy_exc", cae_exception, 16'd0);
        step();
        chk("wd_exc", cae_exception, 16'h0004);
        chk("wd_idle", cae_idle, 1'b1);
        host_rd(NA);
`ifdef CAE_PERF_CNT_EN
        chk("perf_count", cae_ret_data, 64'd28);
`else
        chk("rdNA_again_exc", cae_exception, 16'h0002);
`endif

        // Asynchronous reset mid-BUSY
        inst_aeg_wr = 1; inst_aeg_idx = 18'd2; cae_data = 64'd7;
        step(); clr();
        inst_val = 1;
        step(); clr();
        step();
        chk("pre_rst_stall", cae_stall, 1'b1);
        #2 i_reset = 1'b1;
        #1;
        chk("async_idle", cae_idle, 1'b1);
        chk("async_stall", cae_stall, 1'b0);
        @(posedge clk); #2 i_reset = 1'b0;
        @(negedge clk); #1;
        host_rd(2);
        chk("aeg2_cleared_vld", cae_ret_data_vld, 1'b1);
        chk("aeg2_cleared", cae_ret_data, 64'd0);
        step();

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
